// File: rtl/serv_dbus_if_pkg.sv
// Shared encodings and small decode helpers for the serial data-bus interface.
package serv_dbus_if_pkg;

   // Access size as presented by the core; 2'b11 behaves as a word access.
   typedef enum logic [1:0] {
      SizeByte    = 2'b00,
      SizeHalf    = 2'b01,
      SizeWord    = 2'b10,
      SizeWordAlt = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StBus   = 2'b01,
      StRdata = 2'b10
   } state_e;

   localparam int unsigned DataW = 32;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
      return ((size == SizeHalf) & lsb[0]) | (size[1] & (lsb != 2'b00));
   endfunction

   function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] lsb);
      logic [3:0] sel;
      case (size)
         SizeByte: sel = 4'b0001 << lsb;
         SizeHalf: sel = lsb[1] ? 4'b1100 : 4'b0011;
         default:  sel = 4'b1111;
      endcase
      return sel;
   endfunction

   // Width in bits of the accessed field.
   function automatic logic [5:0] size_width(input logic [1:0] size);
      logic [5:0] w;
      case (size)
         SizeByte: w = 6'd8;
         SizeHalf: w = 6'd16;
         default:  w = 6'd32;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/serv_dbus_if_if.sv
// Bundle of core-side serial signals and Wishbone-side bus signals.
interface serv_dbus_if_if
   import serv_dbus_if_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1
);
   logic [31:0]               i_adr;
   logic [1:0]                i_lsb;
   logic [1:0]                i_size;
   logic                      i_signed;
   logic                      i_we;
   logic                      i_req;
   logic                      i_wen;
   logic [BITS_PER_CYCLE-1:0] i_wdata;
   logic                      i_ren;
   logic [BITS_PER_CYCLE-1:0] o_rdata;
   logic                      o_misalign;
   logic                      o_ack;
   logic [31:0]               o_wb_adr;
   logic [31:0]               o_wb_dat;
   logic [3:0]                o_wb_sel;
   logic                      o_wb_we;
   logic                      o_wb_cyc;
   logic [31:0]               i_wb_rdt;
   logic                      i_wb_ack;

   // Interface block's own view: it consumes core/bus inputs and drives the outputs.
   modport master (
      input  i_adr, i_lsb, i_size, i_signed, i_we, i_req, i_wen, i_wdata, i_ren,
      input  i_wb_rdt, i_wb_ack,
      output o_rdata, o_misalign, o_ack, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
   );

   // Environment view: core plus Wishbone slave.
   modport slave (
      output i_adr, i_lsb, i_size, i_signed, i_we, i_req, i_wen, i_wdata, i_ren,
      output i_wb_rdt, i_wb_ack,
      input  o_rdata, o_misalign, o_ack, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
   );

endinterface

// File: rtl/serv_dbus_ext.sv
// Load-data extract/extend mux: picks one serial beat out of the loaded word.
module serv_dbus_ext
   import serv_dbus_if_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int unsigned CntW           = 5
) (
   input  logic [31:0]               dat_i,
   input  logic [1:0]                lsb_i,
   input  logic [1:0]                size_i,
   input  logic                      signed_i,
   input  logic [CntW-1:0]           cnt_i,
   output logic [BITS_PER_CYCLE-1:0] bits_o
);
   logic [5:0] width;
   logic [5:0] base;
   logic [5:0] idx;
   logic [4:0] msb_pos;
   logic [4:0] pos;
   logic       fill;

   // Bits past the accessed field are replaced by the sign bit or zero.
   always_comb begin
      width   = size_width(size_i);
      base    = {1'b0, lsb_i, 3'b000};
      msb_pos = 5'(base + width - 6'd1);
      fill    = signed_i & dat_i[msb_pos];
      idx     = '0;
      pos     = '0;
      bits_o  = '0;
      for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
         idx       = 6'(cnt_i) * 6'(BITS_PER_CYCLE) + 6'(j);
         pos       = 5'(base + idx);
         bits_o[j] = (idx >= width) ? fill : dat_i[pos];
      end
   end

endmodule

// File: rtl/serv_dbus_if.sv
// Serial-to-Wishbone data bus adapter: gathers store data serially, runs one
// bus cycle, then streams load data back serially with sign/zero extension.
module serv_dbus_if
   import serv_dbus_if_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input logic            i_clk,
   input logic            i_rst,
   serv_dbus_if_if.master bus
);
   localparam int unsigned Beats = DataW / BITS_PER_CYCLE;
   localparam int unsigned CntW  = $clog2(Beats);

   state_e                    state_q, state_d;
   logic [31:0]               dat_q, dat_d;
   logic [31:0]               adr_q, adr_d;
   logic [3:0]                sel_q, sel_d;
   logic                      we_q, we_d;
   logic                      cyc_q, cyc_d;
   logic                      ack_q, ack_d;
   logic                      signed_q, signed_d;
   logic [1:0]                size_q, size_d;
   logic [1:0]                lsb_q, lsb_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      misalign;
   logic                      last_beat;
   logic [31:0]               wb_dat;
   logic [BITS_PER_CYCLE-1:0] ext_bits;
   logic                      unused_adr;

   // Word address only; the byte offset arrives separately on i_lsb.
   assign unused_adr = ^bus.i_adr[1:0];

   assign misalign  = misaligned(bus.i_size, bus.i_lsb);
   assign last_beat = (cnt_q == CntW'(Beats - 1));

   // Next-state and datapath updates for the three-state transaction FSM.
   always_comb begin
      state_d  = state_q;
      dat_d    = dat_q;
      adr_d    = adr_q;
      sel_d    = sel_q;
      we_d     = we_q;
      cyc_d    = cyc_q;
      ack_d    = 1'b0;
      signed_d = signed_q;
      size_d   = size_q;
      lsb_d    = lsb_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.i_req) begin
               // A misaligned request is simply dropped; the core traps on o_misalign.
               if (!misalign) begin
                  state_d  = StBus;
                  cyc_d    = 1'b1;
                  adr_d    = {bus.i_adr[31:2], 2'b00};
                  we_d     = bus.i_we;
                  size_d   = bus.i_size;
                  lsb_d    = bus.i_lsb;
                  signed_d = bus.i_signed;
                  sel_d    = byte_sel(bus.i_size, bus.i_lsb);
               end
            end else if (bus.i_wen) begin
               dat_d = {bus.i_wdata, dat_q[31:BITS_PER_CYCLE]};
            end
         end
         StBus: begin
            if (bus.i_wb_ack) begin
               cyc_d = 1'b0;
               ack_d = 1'b1;
               if (we_q) begin
                  state_d = StIdle;
               end else begin
                  dat_d   = bus.i_wb_rdt;
                  cnt_d   = '0;
                  state_d = StRdata;
               end
            end
         end
         StRdata: begin
            if (bus.i_ren) begin
               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= StIdle;
         dat_q    <= '0;
         adr_q    <= '0;
         sel_q    <= '0;
         we_q     <= 1'b0;
         cyc_q    <= 1'b0;
         ack_q    <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= '0;
         lsb_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         dat_q    <= dat_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         cyc_q    <= cyc_d;
         ack_q    <= ack_d;
         signed_q <= signed_d;
         size_q   <= size_d;
         lsb_q    <= lsb_d;
         cnt_q    <= cnt_d;
      end
   end

   // Replicate narrow store data across all byte lanes.
   always_comb begin
      wb_dat = dat_q;
      case (size_q)
         SizeByte: wb_dat = {4{dat_q[7:0]}};
         SizeHalf: wb_dat = {2{dat_q[15:0]}};
         default:  wb_dat = dat_q;
      endcase
   end

   serv_dbus_ext #(
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .CntW           (CntW)
   ) u_ext (
      .dat_i    (dat_q),
      .lsb_i    (lsb_q),
      .size_i   (size_q),
      .signed_i (signed_q),
      .cnt_i    (cnt_q),
      .bits_o   (ext_bits)
   );

   assign bus.o_rdata    = (bus.i_ren && (state_q == StRdata)) ? ext_bits : '0;
   assign bus.o_misalign = misalign;
   assign bus.o_ack      = ack_q;
   assign bus.o_wb_adr   = adr_q;
   assign bus.o_wb_dat   = wb_dat;
   assign bus.o_wb_sel   = sel_q;
   assign bus.o_wb_we    = we_q;
   assign bus.o_wb_cyc   = cyc_q;

endmodule

// File: tb/tb_serv_dbus_if.sv
// Directed bench: runs the 1-bit and 4-bit variants side by side in lockstep.
module tb_serv_dbus_if;
   logic        clk = 1'b0;
   logic        rst;
   int unsigned checks = 0;
   int unsigned errors = 0;

   serv_dbus_if_if #(.BITS_PER_CYCLE(1)) b1 ();
   serv_dbus_if_if #(.BITS_PER_CYCLE(4)) b4 ();

   serv_dbus_if #(.BITS_PER_CYCLE(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(b1));
   serv_dbus_if #(.BITS_PER_CYCLE(4)) u_dut4 (.i_clk(clk), .i_rst(rst), .bus(b4));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      b1.i_req = 1'b0; b4.i_req = 1'b0;
      b1.i_wen = 1'b0; b4.i_wen = 1'b0;
      b1.i_ren = 1'b0; b4.i_ren = 1'b0;
      b1.i_wb_ack = 1'b0; b4.i_wb_ack = 1'b0;
   endtask

   task automatic set_req(input logic [31:0] adr, input logic [1:0] lsb, input logic [1:0] size,
                          input logic sgn, input logic we);
      b1.i_adr = adr; b4.i_adr = adr;
      b1.i_lsb = lsb; b4.i_lsb = lsb;
      b1.i_size = size; b4.i_size = size;
      b1.i_signed = sgn; b4.i_signed = sgn;
      b1.i_we = we; b4.i_we = we;
      b1.i_req = 1'b1; b4.i_req = 1'b1;
   endtask

   // LSB-first: 32 one-bit beats for b1, 8 nibble beats for b4 over the same window.
   task automatic shift_word(input logic [31:0] w);
      for (int i = 0; i < 32; i++) begin
         b1.i_wen = 1'b1;
         b1.i_wdata = w[i];
         b4.i_wen = (i < 8);
         b4.i_wdata = (i < 8) ? w[4*i +: 4] : 4'h0;
         step();
      end
      b1.i_wen = 1'b0; b4.i_wen = 1'b0;
   endtask

   task automatic check_bus(input string t, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic we);
      @(negedge clk);
      chk({t, ".cyc1"}, b1.o_wb_cyc, 1);  chk({t, ".cyc4"}, b4.o_wb_cyc, 1);
      chk({t, ".adr1"}, b1.o_wb_adr, adr); chk({t, ".adr4"}, b4.o_wb_adr, adr);
      chk({t, ".sel1"}, b1.o_wb_sel, sel); chk({t, ".sel4"}, b4.o_wb_sel, sel);
      chk({t, ".dat1"}, b1.o_wb_dat, dat); chk({t, ".dat4"}, b4.o_wb_dat, dat);
      chk({t, ".we1"}, b1.o_wb_we, we);    chk({t, ".we4"}, b4.o_wb_we, we);
      step();
   endtask

   task automatic do_ack(input string t, input logic [31:0] rdt);
      b1.i_wb_rdt = rdt; b4.i_wb_rdt = rdt;
      b1.i_wb_ack = 1'b1; b4.i_wb_ack = 1'b1;
      step();
      b1.i_wb_ack = 1'b0; b4.i_wb_ack = 1'b0;
      @(negedge clk);
      chk({t, ".ack1"}, b1.o_ack, 1);   chk({t, ".ack4"}, b4.o_ack, 1);
      chk({t, ".cyc0_1"}, b1.o_wb_cyc, 0); chk({t, ".cyc0_4"}, b4.o_wb_cyc, 0);
      step();
      @(negedge clk);
      chk({t, ".ackend1"}, b1.o_ack, 0); chk({t, ".ackend4"}, b4.o_ack, 0);
      step();
   endtask

   // Collect the serial stream with periodic i_ren gaps; rdata must be 0 when not requested.
   task automatic read_word(input string t, input logic [31:0] exp);
      logic [31:0] r1, r4;
      int          n1, n4, cnt;
      bit          gap, quiet_ok;
      r1 = '0; r4 = '0; n1 = 0; n4 = 0; cnt = 0; quiet_ok = 1'b1;
      while ((n1 < 32 || n4 < 8) && cnt < 100) begin
         gap = (cnt % 5 == 2);
         b1.i_ren = !gap && (n1 < 32);
         b4.i_ren = !gap && (n4 < 8);
         @(negedge clk);
         if (b1.i_ren) begin
            r1[n1] = b1.o_rdata; n1++;
         end else if (b1.o_rdata !== 1'b0) begin
            quiet_ok = 1'b0;
         end
         if (b4.i_ren) begin
            r4[4*n4 +: 4] = b4.o_rdata; n4++;
         end else if (b4.o_rdata !== 4'h0) begin
            quiet_ok = 1'b0;
         end
         step();
         cnt++;
      end
      b1.i_ren = 1'b0; b4.i_ren = 1'b0;
      chk({t, ".beats1"}, n1, 32); chk({t, ".beats4"}, n4, 8);
      chk({t, ".rd1"}, r1, exp);   chk({t, ".rd4"}, r4, exp);
      chk({t, ".quiet"}, quiet_ok, 1);
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      set_req(32'h0, 2'b00, 2'b10, 1'b0, 1'b0);
      b1.i_req = 1'b0; b4.i_req = 1'b0;
      b1.i_wdata = '0; b4.i_wdata = '0;
      b1.i_wb_rdt = '0; b4.i_wb_rdt = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.cyc1", b1.o_wb_cyc, 0); chk("rst.cyc4", b4.o_wb_cyc, 0);
      chk("rst.ack1", b1.o_ack, 0);    chk("rst.ack4", b4.o_ack, 0);
      chk("rst.adr", b1.o_wb_adr, 0);  chk("rst.sel", b1.o_wb_sel, 0);
      chk("rst.we", b1.o_wb_we, 0);    chk("rst.dat", b4.o_wb_dat, 0);
      step();
      rst = 1'b0;
      step();

      // Misalign decode is purely combinational.
      set_req(32'h0, 2'b10, 2'b10, 1'b0, 1'b0); b1.i_req = 1'b0; b4.i_req = 1'b0;
      #1 chk("mis.word_lsb2", b1.o_misalign, 1);
      b1.i_size = 2'b00; b1.i_lsb = 2'b11;
      #1 chk("mis.byte_lsb3", b1.o_misalign, 0);
      b4.i_size = 2'b01; b4.i_lsb = 2'b10;
      #1 chk("mis.half_lsb2", b4.o_misalign, 0);
      b4.i_size = 2'b11; b4.i_lsb = 2'b01;
      #1 chk("mis.size3_lsb1", b4.o_misalign, 1);
      step();

      // Word store; address bits [1:0] are dropped.
      shift_word(32'hDEADBEEF);
      set_req(32'h0000_0103, 2'b00, 2'b10, 1'b0, 1'b1);
      step();
      clear_in();
      check_bus("wst", 32'h100, 4'hF, 32'hDEADBEEF, 1'b1);
      // i_req and i_wen during BUS must not disturb the bus cycle.
      set_req(32'h0000_0700, 2'b00, 2'b10, 1'b0, 1'b0);
      b1.i_wen = 1'b1; b1.i_wdata = 1'b1; b4.i_wen = 1'b1; b4.i_wdata = 4'hF;
      step();
      step();
      clear_in();
      @(negedge clk);
      chk("wst.hold_adr", b1.o_wb_adr, 32'h100); chk("wst.hold_dat", b4.o_wb_dat, 32'hDEADBEEF);
      chk("wst.noack1", b1.o_ack, 0);            chk("wst.hold_cyc4", b4.o_wb_cyc, 1);
      step();
      do_ack("wst", 32'h0);

      // Byte store at lsb 2; i_wen in the request cycle is ignored.
      shift_word(32'h000000A5);
      set_req(32'h0000_0204, 2'b10, 2'b00, 1'b0, 1'b1);
      b1.i_wen = 1'b1; b1.i_wdata = 1'b1; b4.i_wen = 1'b1; b4.i_wdata = 4'hF;
      step();
      clear_in();
      check_bus("bst", 32'h204, 4'b0100, 32'hA5A5A5A5, 1'b1);
      do_ack("bst", 32'h0);

      // Signed byte load at lsb 3.
      set_req(32'h0000_0300, 2'b11, 2'b00, 1'b1, 1'b0);
      step();
      clear_in();
      check_bus("lbs", 32'h300, 4'b1000, 32'hA5A5A5A5, 1'b0);
      do_ack("lbs", 32'h80123456);
      read_word("lbs", 32'hFFFFFF80);

      // Same access unsigned; data register now holds the previous load.
      set_req(32'h0000_0300, 2'b11, 2'b00, 1'b0, 1'b0);
      step();
      clear_in();
      check_bus("lbu", 32'h300, 4'b1000, 32'h56565656, 1'b0);
      do_ack("lbu", 32'h80123456);
      read_word("lbu", 32'h00000080);

      // Misaligned half: no bus cycle, and a stray wb ack in IDLE is ignored.
      set_req(32'h0000_0600, 2'b01, 2'b01, 1'b1, 1'b0);
      @(negedge clk);
      chk("mh.mis1", b1.o_misalign, 1); chk("mh.mis4", b4.o_misalign, 1);
      step();
      clear_in();
      b1.i_wb_ack = 1'b1; b4.i_wb_ack = 1'b1;
      @(negedge clk);
      chk("mh.cyc1", b1.o_wb_cyc, 0); chk("mh.cyc4", b4.o_wb_cyc, 0);
      step();
      clear_in();
      @(negedge clk);
      chk("mh.ack1", b1.o_ack, 0); chk("mh.ack4", b4.o_ack, 0);
      chk("mh.cyc1b", b1.o_wb_cyc, 0);
      step();

      // Signed half load at lsb 2, with i_ren in the request cycle.
      set_req(32'h0000_0800, 2'b10, 2'b01, 1'b1, 1'b0);
      b1.i_ren = 1'b1; b4.i_ren = 1'b1;
      step();
      clear_in();
      check_bus("lh", 32'h800, 4'b1100, 32'h34563456, 1'b0);
      do_ack("lh", 32'h7FFF0000);
      read_word("lh", 32'h00007FFF);

      // Reset in the middle of a bus cycle.
      shift_word(32'hCAFEF00D);
      set_req(32'h0000_0400, 2'b00, 2'b10, 1'b0, 1'b1);
      step();
      clear_in();
      check_bus("rb", 32'h400, 4'hF, 32'hCAFEF00D, 1'b1);
      rst = 1'b1;
      #1;
      chk("rb.async_cyc1", b1.o_wb_cyc, 0); chk("rb.async_cyc4", b4.o_wb_cyc, 0);
      step();
      rst = 1'b0;
      step();
      b1.i_wb_ack = 1'b1; b4.i_wb_ack = 1'b1;
      step();
      clear_in();
      @(negedge clk);
      chk("rb.ack1", b1.o_ack, 0);    chk("rb.ack4", b4.o_ack, 0);
      chk("rb.cyc1", b1.o_wb_cyc, 0); chk("rb.adr", b1.o_wb_adr, 0);
      chk("rb.sel", b4.o_wb_sel, 0);  chk("rb.we", b4.o_wb_we, 0);
      step();

      // IDLE after reset: a word load goes straight through, data register cleared.
      set_req(32'h0000_0500, 2'b00, 2'b10, 1'b1, 1'b0);
      step();
      clear_in();
      check_bus("lw", 32'h500, 4'hF, 32'h0, 1'b0);
      do_ack("lw", 32'h12345678);
      read_word("lw", 32'h12345678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
